// File: rtl/register_file_hilo.sv
// register_file_hilo
// Write-back end of the pipeline: 32-entry GPR file (r0 hard-wired to zero)
// plus the HI/LO special registers. Reads are combinational with a same-cycle
// bypass from the write-back bundle, so a consumer never waits a cycle for a
// value that is being retired right now.
module register_file_hilo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  register_write_enable_i,
  input  logic [ADDR_WIDTH-1:0] register_write_address_i,
  input  logic [DATA_WIDTH-1:0] register_write_data_i,
  input  logic                  register_hi_write_enable_i,
  input  logic [DATA_WIDTH-1:0] register_hi_write_data_i,
  input  logic                  register_lo_write_enable_i,
  input  logic [DATA_WIDTH-1:0] register_lo_write_data_i,
  input  logic                  register_read_enable_0_i,
  input  logic [ADDR_WIDTH-1:0] register_read_address_0_i,
  output logic [DATA_WIDTH-1:0] register_read_data_0_o,
  input  logic                  register_read_enable_1_i,
  input  logic [ADDR_WIDTH-1:0] register_read_address_1_i,
  output logic [DATA_WIDTH-1:0] register_read_data_1_o,
  output logic [DATA_WIDTH-1:0] register_hi_data_o,
  output logic [DATA_WIDTH-1:0] register_lo_data_o
);

  localparam int REG_COUNT = 2 ** ADDR_WIDTH;

  // r0 has no storage; the array starts at index 1.
  logic [DATA_WIDTH-1:0] gpr_r [1:REG_COUNT-1];
  logic [DATA_WIDTH-1:0] hi_r;
  logic [DATA_WIDTH-1:0] lo_r;

  logic                  gpr_write_s;
  logic [DATA_WIDTH-1:0] read_data_0_s;
  logic [DATA_WIDTH-1:0] read_data_1_s;
  logic [DATA_WIDTH-1:0] hi_data_s;
  logic [DATA_WIDTH-1:0] lo_data_s;

  // A GPR write only takes effect for a nonzero address.
  assign gpr_write_s = register_write_enable_i &&
                       (register_write_address_i != {ADDR_WIDTH{1'b0}});

  // GPR storage: reset clears every entry and discards the write bundle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 32'sd1; i < REG_COUNT; i++) begin
        gpr_r[i[ADDR_WIDTH-1:0]] <= {DATA_WIDTH{1'b0}};
      end
    end else if (gpr_write_s) begin
      gpr_r[register_write_address_i] <= register_write_data_i;
    end else begin
      gpr_r[register_write_address_i] <= gpr_r[register_write_address_i];
    end
  end

  // HI/LO storage: independent strobes, hold when the strobe is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_r <= {DATA_WIDTH{1'b0}};
      lo_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (register_hi_write_enable_i) begin
        hi_r <= register_hi_write_data_i;
      end else begin
        hi_r <= hi_r;
      end
      if (register_lo_write_enable_i) begin
        lo_r <= register_lo_write_data_i;
      end else begin
        lo_r <= lo_r;
      end
    end
  end

  // Read port 0: reset, disable and r0 force zero; a matching write bypasses.
  always_comb begin
    read_data_0_s = {DATA_WIDTH{1'b0}};
    if (reset) begin
      read_data_0_s = {DATA_WIDTH{1'b0}};
    end else if (!register_read_enable_0_i) begin
      read_data_0_s = {DATA_WIDTH{1'b0}};
    end else if (register_read_address_0_i == {ADDR_WIDTH{1'b0}}) begin
      read_data_0_s = {DATA_WIDTH{1'b0}};
    end else if (register_write_enable_i &&
                 (register_write_address_i == register_read_address_0_i)) begin
      read_data_0_s = register_write_data_i;
    end else begin
      read_data_0_s = gpr_r[register_read_address_0_i];
    end
  end

  // Read port 1: same resolution as port 0, evaluated independently.
  always_comb begin
    read_data_1_s = {DATA_WIDTH{1'b0}};
    if (reset) begin
      read_data_1_s = {DATA_WIDTH{1'b0}};
    end else if (!register_read_enable_1_i) begin
      read_data_1_s = {DATA_WIDTH{1'b0}};
    end else if (register_read_address_1_i == {ADDR_WIDTH{1'b0}}) begin
      read_data_1_s = {DATA_WIDTH{1'b0}};
    end else if (register_write_enable_i &&
                 (register_write_address_i == register_read_address_1_i)) begin
      read_data_1_s = register_write_data_i;
    end else begin
      read_data_1_s = gpr_r[register_read_address_1_i];
    end
  end

  // HI/LO outputs: zero in reset, otherwise bypass a pending write.
  always_comb begin
    hi_data_s = {DATA_WIDTH{1'b0}};
    lo_data_s = {DATA_WIDTH{1'b0}};
    if (reset) begin
      hi_data_s = {DATA_WIDTH{1'b0}};
      lo_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      if (register_hi_write_enable_i) begin
        hi_data_s = register_hi_write_data_i;
      end else begin
        hi_data_s = hi_r;
      end
      if (register_lo_write_enable_i) begin
        lo_data_s = register_lo_write_data_i;
      end else begin
        lo_data_s = lo_r;
      end
    end
  end

  assign register_read_data_0_o = read_data_0_s;
  assign register_read_data_1_o = read_data_1_s;
  assign register_hi_data_o     = hi_data_s;
  assign register_lo_data_o     = lo_data_s;

endmodule

// File: doc/register_file_hilo.md
Name: register_file_hilo

Overview:
- Write-back end of the CPU pipeline. Holds the 32-entry general-purpose register file and the HI/LO special registers.
- Consumes the write-enable/address/data and HI/LO write-enable/data bundle that the memory stage forwards.
- Supplies two GPR read ports and HI/LO read values to the decode/execute stages.
- Same-cycle write-to-read bypass, so a value written back is visible to a read in the same cycle.

Parameters:
- DATA_WIDTH, 32, width of every register and data port.
- ADDR_WIDTH, 5, GPR address width; register count = 2**ADDR_WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- register_write_enable_i  input  1  GPR write strobe from memory stage.
- register_write_address_i  input  ADDR_WIDTH  GPR write index.
- register_write_data_i  input  DATA_WIDTH  GPR write value.
- register_hi_write_enable_i  input  1  HI write strobe.
- register_hi_write_data_i  input  DATA_WIDTH  HI write value.
- register_lo_write_enable_i  input  1  LO write strobe.
- register_lo_write_data_i  input  DATA_WIDTH  LO write value.
- register_read_enable_0_i  input  1  read port 0 enable.
- register_read_address_0_i  input  ADDR_WIDTH  read port 0 index.
- register_read_data_0_o  output  DATA_WIDTH  read port 0 value (combinational).
- register_read_enable_1_i  input  1  read port 1 enable.
- register_read_address_1_i  input  ADDR_WIDTH  read port 1 index.
- register_read_data_1_o  output  DATA_WIDTH  read port 1 value (combinational).
- register_hi_data_o  output  DATA_WIDTH  current HI value, bypassed.
- register_lo_data_o  output  DATA_WIDTH  current LO value, bypassed.

Behaviour:
- Storage: GPR[1..2**ADDR_WIDTH-1], HI and LO are flops updated on the rising clock edge. GPR[0] has no storage.
- Reset (reset=1 at a rising edge): all GPRs, HI and LO clear to 0. Write strobes sampled in that cycle are discarded. Reset takes priority over any simultaneous write.
- While reset=1, all read outputs are 0 combinationally, independent of enables and bypass.
- GPR write: if register_write_enable_i=1 and address≠0, GPR[address] <= data at the edge. Writes to address 0 are silently dropped.
- HI and LO writes are independent. Both may occur in the same cycle, with or without a GPR write. HI/LO hold their value when the strobe is low.
- Read port n, evaluated in priority order:
  - reset=1 -> 0.
  - read_enable=0 -> 0.
  - address=0 -> 0.
  - write_enable=1 and write_address == read address -> register_write_data_i (bypass, zero latency).
  - otherwise -> stored GPR[address].
- Both read ports may target the same address, including the address being written. Each port resolves independently.
- HI output: reset -> 0; else hi_write_enable=1 -> hi_write_data (bypass); else stored HI. LO output follows the same rule.
- Write latency: a value is stored at the edge ending the write cycle. Same-cycle reads see it via bypass; later cycles read it from storage.
- No stall input. The block accepts exactly one write bundle per cycle.
- Implementation size is about 120-180 lines. The reset clear is a loop over the array.

Test Plan:
- Reset then read: assert reset 2 cycles, then read addr 5 and 31 on both ports -> 0. HI/LO outputs -> 0.
- Write/readback: write 0xDEADBEEF to r7. Next cycle read port 0 addr 7 -> 0xDEADBEEF. Read port 1 addr 8 -> 0.
- r0 protection: write 0x12345678 to addr 0. Same cycle and next cycle, read addr 0 on both ports -> 0 (no bypass).
- Bypass: r3 holds 0x1. In one cycle write 0x55AA55AA to r3 while port 0 and port 1 both read r3 -> both 0x55AA55AA. Next cycle with no write -> 0x55AA55AA.
- HI/LO:
  - Same cycle: hi_we=1 data 0xAAAA0000, lo_we=1 data 0x0000BBBB -> outputs show both values in that cycle.
  - Next cycle: strobes low -> values held.
  - Then lo_we only, data 0x1 -> HI stays 0xAAAA0000, LO becomes 0x1.
- Reset mid-operation:
  - Reset=1 together with a write of 0xCAFEF00D to r9 and hi_we=1 -> outputs 0 during reset.
  - After reset, r9 reads 0 and HI reads 0.
  - Read disabled with a nonzero address -> 0.
